// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
// Holds the controller state enum, the default lane count and lane width,
// and the per-lane arithmetic helpers (saturating add, ReLU) used by the
// datapath. Lane width is fixed here, so every user agrees on psum_t.
package psum_accumulator_pkg;

    localparam int PSUM_BW     = 16;
    localparam int COL_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_WAIT_ITER,
        ST_DRAIN,
        ST_DONE
    } acc_state_e;

    typedef logic signed [PSUM_BW-1:0] psum_t;

    localparam psum_t PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam psum_t PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // Signed add clamped to the lane range. One guard bit is enough; the
    // two top bits disagreeing means the true sum left the lane range.
    function automatic psum_t sat_add(input psum_t a, input psum_t b);
        logic [PSUM_BW:0] sum;
        sum = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
            return sum[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
        end
        return sum[PSUM_BW-1:0];
    endfunction

    function automatic psum_t relu(input psum_t x);
        return x[PSUM_BW-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Data-path bus for the partial-sum accumulator.
// in_*  : partial-sum vectors from the array (valid/ready, lane 0 in LSBs)
// out_* : final result vectors to the consumer (valid/ready)
// slave modport is the accumulator side, master is the producer/consumer side.
interface psum_accumulator_if #(
    parameter int COL = psum_accumulator_pkg::COL_DEFAULT
) ();
    localparam int W = COL * psum_accumulator_pkg::PSUM_BW;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_accumulator_lane_add.sv
// One lane of the accumulate datapath.
// acc_i   : value currently stored for this lane
// add_i   : incoming partial sum for this lane
// first_i : first kernel iteration, incoming value replaces the stored one
// sum_o   : value to write back
module psum_lane_add
    import psum_accumulator_pkg::*;
(
    input  psum_t acc_i,
    input  psum_t add_i,
    input  logic  first_i,
    output psum_t sum_o
);

    assign sum_o = first_i ? add_i : sat_add(acc_i, add_i);

endmodule

// File: rtl/psum_accumulator.sv
// Accumulation stage behind the systolic array.
// Collects NUM_OUT vectors per kernel iteration into a register store,
// saturating-accumulating across KIJ_LEN iterations, then drains the store
// (optionally ReLU'd) through the out_* handshake.
// clk, reset        : clock, synchronous active-high reset
// start             : level; its rising edge begins a new computation
// iter_done         : controller pulse closing the current iteration
// relu_en           : ReLU on drain, captured at the start edge
// acc_done          : all results drained
// underrun          : sticky, an iteration closed before it was complete
// bus               : in_*/out_* vector handshakes
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int COL     = COL_DEFAULT,
    parameter int NUM_OUT = 64,
    parameter int KIJ_LEN = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic iter_done,
    input  logic relu_en,
    output logic acc_done,
    output logic underrun,
    psum_accumulator_if.slave bus
);

    localparam int W  = COL * PSUM_BW;
    localparam int AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int IW = (KIJ_LEN > 1) ? $clog2(KIJ_LEN) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OUT - 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(KIJ_LEN - 1);

    acc_state_e    state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          underrun_q, underrun_d;
    logic          relu_q, relu_d;
    logic          start_q;

    logic [W-1:0]  mem [NUM_OUT];
    logic [W-1:0]  rmw_old;
    logic [W-1:0]  rmw_new;
    logic [W-1:0]  rd_vec;

    logic          start_edge;
    logic          wr_en;
    logic          iter_end;

    assign start_edge = start & ~start_q;
    // A start edge wins over everything, including a same-cycle accept.
    assign wr_en      = (state_q == ST_ACCUM) & bus.in_valid & ~start_edge & ~reset;
    // An early iter_done in ACCUM is handled exactly like one in WAIT_ITER.
    assign iter_end   = iter_done & ((state_q == ST_ACCUM) | (state_q == ST_WAIT_ITER));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            underrun_q <= 1'b0;
            relu_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            underrun_q <= underrun_d;
            relu_q     <= relu_d;
            start_q    <= start;
        end
    end

    // Store has no reset; unwritten addresses keep old contents on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr_q] <= rmw_new;
        end
    end

    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        waddr_d       = waddr_q;
        raddr_d       = raddr_q;
        underrun_d    = underrun_q;
        relu_d        = relu_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        acc_done      = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    waddr_d = waddr_q + 1'b1;
                    if (waddr_q == LAST_ADDR) begin
                        state_d = ST_WAIT_ITER;
                    end
                end
                // Only short if the same-cycle accept did not complete the set.
                if (iter_done && !(bus.in_valid && (waddr_q == LAST_ADDR))) begin
                    underrun_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    raddr_d = raddr_q + 1'b1;
                    if (raddr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                acc_done = 1'b1;
            end
            default: begin
            end
        endcase

        if (iter_end) begin
            if (iter_q == LAST_ITER) begin
                state_d = ST_DRAIN;
                raddr_d = '0;
            end else begin
                state_d = ST_ACCUM;
                iter_d  = iter_q + 1'b1;
                waddr_d = '0;
            end
        end

        if (start_edge) begin
            state_d    = ST_ACCUM;
            iter_d     = '0;
            waddr_d    = '0;
            underrun_d = 1'b0;
            relu_d     = relu_en;
        end
    end

    assign underrun = underrun_q;
    assign rmw_old  = mem[waddr_q];
    assign rd_vec   = mem[raddr_q];

    for (genvar gi = 0; gi < COL; gi++) begin : g_lane
        psum_lane_add u_lane_add (
            .acc_i   (rmw_old[gi*PSUM_BW +: PSUM_BW]),
            .add_i   (bus.in_data[gi*PSUM_BW +: PSUM_BW]),
            .first_i (iter_q == '0),
            .sum_o   (rmw_new[gi*PSUM_BW +: PSUM_BW])
        );

        assign bus.out_data[gi*PSUM_BW +: PSUM_BW] =
            relu_q ? relu(rd_vec[gi*PSUM_BW +: PSUM_BW]) : rd_vec[gi*PSUM_BW +: PSUM_BW];
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator with a small store (4 addresses, 2 iterations).
// A per-lane integer model tracks the store contents and the expected drain
// order; a compare process checks handshake flags every cycle and each
// drained vector against the model.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    localparam int COL     = 8;
    localparam int NUM_OUT = 4;
    localparam int KIJ_LEN = 2;
    localparam int BW      = 16;
    localparam int W       = COL * BW;

    localparam int PH_IDLE  = 0;
    localparam int PH_ACC   = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic iter_done = 1'b0;
    logic relu_en = 1'b0;
    logic acc_done;
    logic underrun;

    psum_accumulator_if #(.COL(COL)) bus ();

    psum_accumulator #(
        .COL     (COL),
        .NUM_OUT (NUM_OUT),
        .KIJ_LEN (KIJ_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .iter_done (iter_done),
        .relu_en   (relu_en),
        .acc_done  (acc_done),
        .underrun  (underrun),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    int           m_mem [NUM_OUT][COL];
    int           m_phase = PH_IDLE;
    int           m_iter  = 0;
    int           m_count = 0;
    bit           m_under = 1'b0;
    bit           m_relu  = 1'b0;
    bit           chk_en  = 1'b0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int clamp(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic int lane_of(input logic [W-1:0] v, input int l);
        logic signed [BW-1:0] x;
        x = v[l*BW +: BW];
        return int'(x);
    endfunction

    function automatic logic [W-1:0] mkvec(input int l0, input int l1, input int rest);
        logic [W-1:0] v;
        for (int l = 0; l < COL; l++) begin
            v[l*BW +: BW] = BW'((l == 0) ? l0 : (l == 1) ? l1 : rest);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset     = 1'b0;
        m_phase   = PH_IDLE;
        m_under   = 1'b0;
        m_relu    = 1'b0;
        exp_q.delete();
        chk_en    = 1'b1;
    endtask

    task automatic start_run(input bit r);
        relu_en = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
        m_phase = PH_ACC;
        m_iter  = 0;
        m_count = 0;
        m_under = 1'b0;
        m_relu  = r;
        $display("[TB] start relu=%0d", r);
    endtask

    task automatic send(input logic [W-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        step();
        bus.in_valid = 1'b0;
        if (m_phase == PH_ACC) begin
            for (int l = 0; l < COL; l++) begin
                if (m_iter == 0) m_mem[m_count][l] = lane_of(v, l);
                else             m_mem[m_count][l] = clamp(m_mem[m_count][l] + lane_of(v, l));
            end
            $display("[TB] accept addr %0d iter %0d data %h", m_count, m_iter, v);
            m_count++;
            if (m_count == NUM_OUT) m_phase = PH_WAIT;
        end else begin
            $display("[TB] offer %h while not accepting", v);
        end
    endtask

    task automatic pulse_iter();
        logic [W-1:0] v;
        iter_done = 1'b1;
        step();
        iter_done = 1'b0;
        if (m_phase == PH_ACC) m_under = 1'b1;
        if (m_iter == KIJ_LEN - 1) begin
            m_phase = PH_DRAIN;
            for (int a = 0; a < NUM_OUT; a++) begin
                for (int l = 0; l < COL; l++) begin
                    v[l*BW +: BW] = BW'((m_relu && m_mem[a][l] < 0) ? 0 : m_mem[a][l]);
                end
                exp_q.push_back(v);
            end
            $display("[TB] iter_done final, drain of %0d vectors expected", NUM_OUT);
        end else begin
            m_iter++;
            m_count = 0;
            m_phase = PH_ACC;
            $display("[TB] iter_done, next iter %0d", m_iter);
        end
    endtask

    task automatic drain(input logic [7:0] pat);
        int i = 0;
        while (exp_q.size() > 0 && i < 40) begin
            bus.out_ready = pat[i % 8];
            i++;
            step();
        end
        bus.out_ready = 1'b0;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: %0d vectors left, required 0", exp_q.size());
            exp_q.delete();
        end
        m_phase = PH_DONE;
        check("acc_done_after_last", W'(acc_done), W'(1'b1));
    endtask

    // Per-cycle compare against the model.
    logic [W-1:0] prev_data;
    bit           prev_stall = 1'b0;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("in_ready",  W'(bus.in_ready),  W'(m_phase == PH_ACC));
            check("out_valid", W'(bus.out_valid), W'(m_phase == PH_DRAIN));
            check("acc_done",  W'(acc_done),      W'(m_phase == PH_DONE));
            check("underrun",  W'(underrun),      W'(m_under));
            if (prev_stall) check("stall_hold", bus.out_data, prev_data);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL extra_xfer: got %h with no vector expected", bus.out_data);
                end else begin
                    check("drain_data", bus.out_data, exp_q[0]);
                    $display("[TB] drain data %h", bus.out_data);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset();
        check("rst_in_ready",  W'(bus.in_ready),  '0);
        check("rst_out_valid", W'(bus.out_valid), '0);

        // Basic: 5 then 3 -> 8 everywhere, full-rate drain
        start_run(1'b0);
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(5, 5, 5));
        pulse_iter();
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(3, 3, 3));
        pulse_iter();
        check("pin_basic", exp_q[0], mkvec(8, 8, 8));
        drain(8'hFF);

        // Saturation at both rails, other lanes unaffected
        start_run(1'b0);
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(32767, -32768, 100));
        pulse_iter();
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(1, -1, 5));
        pulse_iter();
        check("pin_sat", exp_q[1], mkvec(32767, -32768, 105));
        drain(8'b1001_1001);

        // ReLU on: -7 -> 0, 9 -> 9, -2 -> 0
        start_run(1'b1);
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(-10, 4, -1));
        pulse_iter();
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(3, 5, -1));
        pulse_iter();
        check("pin_relu_on", exp_q[0], mkvec(0, 9, 0));
        drain(8'hFF);

        // Same data with ReLU off
        start_run(1'b0);
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(-10, 4, -1));
        pulse_iter();
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(3, 5, -1));
        pulse_iter();
        check("pin_relu_off", exp_q[3], mkvec(-7, 9, -2));
        drain(8'hFF);

        // Underrun: 2 of 4 then iter_done; addresses 2,3 keep -7/9/-2
        start_run(1'b0);
        send(mkvec(1, 2, 3));
        send(mkvec(1, 2, 3));
        pulse_iter();
        check("underrun_set", W'(underrun), W'(1'b1));
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(10, 10, 10));
        send(mkvec(1000, 1000, 1000));   // fifth vector, must be refused
        pulse_iter();
        check("pin_under_lo", exp_q[0], mkvec(11, 12, 13));
        check("pin_under_hi", exp_q[2], mkvec(3, 19, 8));
        drain(8'b0101_0101);

        // Reset mid-ACCUM, then a fresh run gives the basic result
        start_run(1'b0);
        send(mkvec(500, 500, 500));
        send(mkvec(500, 500, 500));
        do_reset();
        check("rst2_underrun", W'(underrun), '0);
        check("rst2_acc_done", W'(acc_done), '0);
        start_run(1'b0);
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(5, 5, 5));
        pulse_iter();
        for (int a = 0; a < NUM_OUT; a++) send(mkvec(3, 3, 3));
        pulse_iter();
        check("pin_after_reset", exp_q[1], mkvec(8, 8, 8));
        drain(8'b1101_1011);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
